// File: rtl/id_pkg.sv
// Shared definitions for the ID operand-issue slice.
// Holds the register-address width and its typedef. Types whose width depends
// on a module parameter (scoreboard counter, ID/EX bundle) are declared inside
// the modules that own those parameters, so the package stays parameter-free.
package id_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register countdown scoreboard for in-flight multi-cycle writers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               clear every counter
//   pipe_adv            decrement every nonzero counter
//   set_en/addr/lat     load a counter with a writer latency (clamped to MAX_LAT)
//   rs, rt              lookup addresses
//   busy_rs, busy_rt    lookup result: counter for that register is nonzero
module id_scoreboard
  import id_pkg::*;
#(
  parameter int MAX_LAT = 3,
  parameter int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             pipe_adv,
  input  logic             set_en,
  input  reg_addr_t        set_addr,
  input  logic [CNT_W-1:0] set_lat,
  input  reg_addr_t        rs,
  input  reg_addr_t        rt,
  output logic             busy_rs,
  output logic             busy_rt
);

  typedef logic [CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t LAT_MAX = sb_cnt_t'(MAX_LAT);

  // r0 never has a counter; its busy bit is tied to 0 below.
  sb_cnt_t              cnt [NUM_REGS-1:1];
  sb_cnt_t              lat_clamped;
  logic  [NUM_REGS-1:0] busy_vec;

  assign lat_clamped = (set_lat > LAT_MAX) ? LAT_MAX : set_lat;

  // A set on an entry wins over the decrement of that same entry; all other
  // nonzero entries still count down when the pipe advances.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 1; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_addr == reg_addr_t'(i))
          cnt[i] <= lat_clamped;
        else if (pipe_adv && cnt[i] != '0)
          cnt[i] <= cnt[i] - sb_cnt_t'(1);
      end
    end
  end

  always_comb begin
    busy_vec    = '0;
    for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = (cnt[i] != '0);
  end

  assign busy_rs = busy_vec[rs];
  assign busy_rt = busy_vec[rt];

endmodule

// File: rtl/id_operand_issue.sv
// Decode-stage operand resolution and issue into a registered ID/EX bundle.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   id_*                         instruction in ID, handshake id_valid_i/id_ready_o
//   rf_rdata1_i/2_i              register-file read data for rs/rt
//   fwd_we_i/addr_i/data_i       NFWD forwarding ports, port 0 youngest/highest priority
//   pipe_adv_i, flush_i          pipeline advance and kill
//   ex_ready_i, ex_*_o           registered bundle toward EX
//   id_rdata1_o/2_o              combinational resolved operands
//   stall_cnt_o                  saturating hazard-stall cycle count
module id_operand_issue
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NFWD    = 3,
  parameter int MAX_LAT = 3,
  parameter int CNT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  output logic                     id_ready_o,
  input  logic [4:0]               id_rs_i,
  input  logic [4:0]               id_rt_i,
  input  logic [4:0]               id_dst_i,
  input  logic                     id_use_rs_i,
  input  logic                     id_use_rt_i,
  input  logic                     id_wreg_i,
  input  logic [CNT_W-1:0]         id_lat_i,
  input  logic [DATA_W-1:0]        rf_rdata1_i,
  input  logic [DATA_W-1:0]        rf_rdata2_i,
  input  logic [NFWD-1:0]          fwd_we_i,
  input  logic [NFWD*5-1:0]        fwd_addr_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_data_i,
  input  logic                     pipe_adv_i,
  input  logic                     flush_i,
  input  logic                     ex_ready_i,
  output logic                     ex_valid_o,
  output logic [DATA_W-1:0]        ex_rdata1_o,
  output logic [DATA_W-1:0]        ex_rdata2_o,
  output logic [4:0]               ex_dst_o,
  output logic                     ex_wreg_o,
  output logic [DATA_W-1:0]        id_rdata1_o,
  output logic [DATA_W-1:0]        id_rdata2_o,
  output logic [31:0]              stall_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    reg_addr_t         dst;
    logic              wreg;
  } id_ex_bundle_t;

  id_ex_bundle_t bundle;
  logic          bundle_valid;
  logic          busy_rs;
  logic          busy_rt;
  logic          hazard;
  logic          issue;
  logic [31:0]   stall_cnt;

  // Walk ports from oldest to youngest so the lowest matching index wins.
  function automatic logic [DATA_W-1:0] resolve(
    input reg_addr_t                addr,
    input logic [DATA_W-1:0]        rf,
    input logic [NFWD-1:0]          we,
    input logic [NFWD*5-1:0]        faddr,
    input logic [NFWD*DATA_W-1:0]   fdata
  );
    logic [DATA_W-1:0] val;
    val = rf;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (we[i] && faddr[i*REG_AW +: REG_AW] == addr)
        val = fdata[i*DATA_W +: DATA_W];
    end
    if (addr == '0) val = '0;
    return val;
  endfunction

  assign id_rdata1_o = resolve(id_rs_i, rf_rdata1_i, fwd_we_i, fwd_addr_i, fwd_data_i);
  assign id_rdata2_o = resolve(id_rt_i, rf_rdata2_i, fwd_we_i, fwd_addr_i, fwd_data_i);

  id_scoreboard #(
    .MAX_LAT (MAX_LAT),
    .CNT_W   (CNT_W)
  ) u_scoreboard (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (flush_i),
    .pipe_adv (pipe_adv_i),
    .set_en   (issue && id_wreg_i && id_dst_i != '0),
    .set_addr (id_dst_i),
    .set_lat  (id_lat_i),
    .rs       (id_rs_i),
    .rt       (id_rt_i),
    .busy_rs  (busy_rs),
    .busy_rt  (busy_rt)
  );

  assign hazard = id_valid_i && ((id_use_rs_i && busy_rs) || (id_use_rt_i && busy_rt));

  // Reset also holds ready low so nothing appears to issue while the
  // bundle and scoreboard are being cleared.
  assign id_ready_o = !hazard && (!bundle_valid || ex_ready_i) && !flush_i && !rst_i;
  assign issue      = id_valid_i && id_ready_o;

  // Bundle holds under backpressure; it empties when EX takes it and
  // nothing new issues behind it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bundle       <= '0;
      bundle_valid <= 1'b0;
    end else if (flush_i) begin
      bundle_valid <= 1'b0;
    end else if (issue) begin
      bundle.rdata1 <= id_rdata1_o;
      bundle.rdata2 <= id_rdata2_o;
      bundle.dst    <= id_dst_i;
      bundle.wreg   <= id_wreg_i;
      bundle_valid  <= 1'b1;
    end else if (ex_ready_i) begin
      bundle_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      stall_cnt <= '0;
    else if (hazard && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign ex_valid_o  = bundle_valid;
  assign ex_rdata1_o = bundle.rdata1;
  assign ex_rdata2_o = bundle.rdata2;
  assign ex_dst_o    = bundle.dst;
  assign ex_wreg_o   = bundle.wreg;
  assign stall_cnt_o = stall_cnt;

endmodule
